// File: rtl/mac_accum_pkg.sv
// ============================================================================
// Module   : p (package)
// Desc     : Shared widths for the multiply-add datapath and the accumulator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package p;

    localparam int SIZE_REG      = 8;
    localparam int SIZE_DATA_OUT = 2 * SIZE_REG;
    localparam int ACC_LEN_DEF   = 4;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_accum_outbuf.sv
// ============================================================================
// Module   : mac_outbuf
// Desc     : 2-entry valid/ready output buffer; drops a push when full and
//            not popping, and flags it with a sticky overrun bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_outbuf
    import p::*;
#(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_in_ready,
    output logic         o_overrun
);

    buf_state_t   r_state;
    buf_state_t   w_state_nxt;
    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [W-1:0] w_head_nxt;
    logic [W-1:0] w_tail_nxt;
    logic         r_ovr;
    logic         w_ovr_nxt;
    logic         w_pop;

    assign w_pop = (r_state != BUF_EMPTY) && i_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUF_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_ovr_nxt   = r_ovr;
        case (r_state)
            BUF_EMPTY: begin
                if (i_push) begin
                    w_state_nxt = BUF_ONE;
                    w_head_nxt  = i_push_data;
                end
            end
            BUF_ONE: begin
                case ({i_push, w_pop})
                    2'b10: begin
                        w_state_nxt = BUF_TWO;
                        w_tail_nxt  = i_push_data;
                    end
                    2'b01: w_state_nxt = BUF_EMPTY;
                    2'b11: w_head_nxt  = i_push_data;
                    default: ;
                endcase
            end
            BUF_TWO: begin
                // A push coinciding with a pop frees a slot, so it is not an overrun.
                case ({i_push, w_pop})
                    2'b10: w_ovr_nxt = 1'b1;
                    2'b01: begin
                        w_state_nxt = BUF_ONE;
                        w_head_nxt  = r_tail;
                    end
                    2'b11: begin
                        w_head_nxt = r_tail;
                        w_tail_nxt = i_push_data;
                    end
                    default: ;
                endcase
            end
            default: w_state_nxt = BUF_EMPTY;
        endcase
    end

    assign o_data     = r_head;
    assign o_valid    = (r_state != BUF_EMPTY);
    assign o_in_ready = (r_state != BUF_TWO);
    assign o_overrun  = r_ovr;

endmodule

`default_nettype wire

// File: rtl/mac_accum.sv
// ============================================================================
// Module   : mac_accum
// Desc     : Realigns launch strobes to the 2-clock multiply-add latency and
//            sums every ACC_LEN valid products into one buffered result.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_accum
    import p::*;
#(
    parameter int ACC_LEN  = ACC_LEN_DEF,
    parameter int SIZE_ACC = SIZE_DATA_OUT + $clog2(ACC_LEN)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       launch,
    input  logic [SIZE_DATA_OUT-1:0]   data_in,
    output logic                       in_ready,
    output logic [SIZE_ACC-1:0]        out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    output logic [$clog2(ACC_LEN)-1:0] grp_cnt
);

    localparam int            CW     = $clog2(ACC_LEN);
    localparam logic [CW-1:0] C_LAST = CW'(ACC_LEN - 1);

    logic                r_v1;
    logic                r_v2;
    logic [SIZE_ACC-1:0] r_acc;
    logic [CW-1:0]       r_grp;
    logic [SIZE_ACC-1:0] w_data_ext;
    logic [SIZE_ACC-1:0] w_sum;
    logic                w_push;

    assign w_data_ext = SIZE_ACC'(data_in);
    assign w_sum      = r_acc + w_data_ext;
    // The completed sum goes straight into the buffer so it is registered once.
    assign w_push     = r_v2 && (r_grp == C_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_acc <= '0;
            r_grp <= '0;
        end else begin
            r_v1 <= launch;
            r_v2 <= r_v1;
            if (r_v2) begin
                if (r_grp == C_LAST) begin
                    r_acc <= '0;
                    r_grp <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_grp <= r_grp + 1'b1;
                end
            end
        end
    end

    mac_outbuf #(
        .W (SIZE_ACC)
    ) u_outbuf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_sum),
        .i_ready     (out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_in_ready  (in_ready),
        .o_overrun   (overrun)
    );

    assign grp_cnt = r_grp;

endmodule

`default_nettype wire
